// File: rtl/cy_stream_pkg.sv
// Shared stream-block helpers: pointer/count width functions and default sizes.
// Imported by cy_skid_fifo and its storage sub-module.
package cy_stream_pkg;

  localparam int CY_DW_DEFAULT    = 8;
  localparam int CY_DEPTH_DEFAULT = 2;

  // A single-entry ring still needs a one-bit pointer
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cy_skid_fifo_mem.sv
// DEPTH x DW storage for cy_skid_fifo: one synchronous write port and an
// asynchronous read port. Contents are deliberately left unreset.
module cy_skid_fifo_mem
  import cy_stream_pkg::*;
#(
  parameter int DW    = CY_DW_DEFAULT,
  parameter int DEPTH = CY_DEPTH_DEFAULT,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cy_skid_fifo.sv
// Valid/ready stream buffer: registered output stage plus a DEPTH-entry ring.
// Optional synchronous flush port enabled by defining CY_SKID_FIFO_FLUSH_EN.
module cy_skid_fifo
  import cy_stream_pkg::*;
#(
  parameter int DW    = CY_DW_DEFAULT,
  parameter int DEPTH = CY_DEPTH_DEFAULT,
  localparam int CW   = $clog2(DEPTH + 2)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
`ifdef CY_SKID_FIFO_FLUSH_EN
  input  logic          i_flush,
`endif
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int BW = cnt_w(DEPTH);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [BW-1:0] r_cnt;
  logic          r_ready, r_valid;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_count;

  logic          w_accept, w_ld, w_empty, w_wr, w_rd, w_we;
  logic          w_valid_nxt;
  logic [BW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [DW-1:0] w_rdata;

  assign w_accept = i_valid && r_ready;
  assign w_ld     = !r_valid || i_ready;
  assign w_empty  = (r_cnt == '0);

  // Bypass straight to the output stage when the ring is empty and it can load
  assign w_wr = w_accept && !(w_ld && w_empty);
  assign w_rd = w_ld && !w_empty;

  assign w_cnt_nxt    = r_cnt + BW'(w_wr) - BW'(w_rd);
  assign w_valid_nxt  = w_ld ? (!w_empty || w_accept) : 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

`ifdef CY_SKID_FIFO_FLUSH_EN
  assign w_we = w_wr && !i_flush;
`else
  assign w_we = w_wr;
`endif

  cy_skid_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
    end
`ifdef CY_SKID_FIFO_FLUSH_EN
    else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end
`endif
    else begin
      if (w_wr) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd) r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt < BW'(DEPTH));
      r_valid <= w_valid_nxt;
      r_count <= CW'(w_cnt_nxt) + CW'(w_valid_nxt);
      if (w_ld) begin
        if (!w_empty)      r_data <= w_rdata;
        else if (w_accept) r_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: tb/tb_cy_skid_fifo.sv
// Bench for cy_skid_fifo: directed scenarios on a DEPTH=2 instance and a
// randomized run on a DEPTH=3 instance, both against a queue-based model.
module tb_cy_skid_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid = 0, a_rdy_dn = 0, a_flush = 0;
  logic [7:0] a_data = 0;
  logic       a_o_ready, a_o_valid;
  logic [7:0] a_o_data;
  logic [1:0] a_o_count;

  logic       b_valid = 0, b_rdy_dn = 0;
  logic [7:0] b_data = 0;
  logic       b_o_ready, b_o_valid;
  logic [7:0] b_o_data;
  logic [2:0] b_o_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         ra_m = 0, rb_m = 0;

  always #5 clk = ~clk;

  cy_skid_fifo #(.DW(8), .DEPTH(2)) u_dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
`ifdef CY_SKID_FIFO_FLUSH_EN
    .i_flush   (a_flush),
`endif
    .i_valid   (a_valid),
    .o_ready   (a_o_ready),
    .i_data    (a_data),
    .o_valid   (a_o_valid),
    .i_ready   (a_rdy_dn),
    .o_data    (a_o_data),
    .o_count   (a_o_count)
  );

  cy_skid_fifo #(.DW(8), .DEPTH(3)) u_dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
`ifdef CY_SKID_FIFO_FLUSH_EN
    .i_flush   (1'b0),
`endif
    .i_valid   (b_valid),
    .o_ready   (b_o_ready),
    .i_data    (b_data),
    .o_valid   (b_o_valid),
    .i_ready   (b_rdy_dn),
    .o_data    (b_o_data),
    .o_count   (b_o_count)
  );

  // Model: each queue holds every beat inside the block, head = beat on o_data.
  // The block can hold DEPTH+1 beats; o_ready reflects room after each edge.
  task automatic tick();
    bit pa, aa, pb, ab;
    pa = (qa.size() > 0) && a_rdy_dn;
    aa = a_valid && ra_m;
    pb = (qb.size() > 0) && b_rdy_dn;
    ab = b_valid && rb_m;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ra_m = 0; rb_m = 0;
    end else begin
      if (a_flush) qa.delete();
      else begin
        if (pa) void'(qa.pop_front());
        if (aa) qa.push_back(a_data);
      end
      if (pb) void'(qb.pop_front());
      if (ab) qb.push_back(b_data);
      ra_m = (qa.size() <= 2);
      rb_m = (qb.size() <= 3);
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_o_valid, a_o_ready, a_o_count, a_o_data} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: got v=%0b r=%0b cnt=%0d d=%02h, want all zero",
               a_o_valid, a_o_ready, a_o_count, a_o_data);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got r=%0b v=%0b, want r=1 v=0", a_o_ready, a_o_valid);
    end
  endtask

  task automatic test_streaming();
    a_rdy_dn = 1; a_valid = 1;
    for (int i = 1; i <= 16; i++) begin
      a_data = 8'(i);
      tick();
      checks++;
      if (a_o_valid !== 1'b1 || a_o_data !== 8'(i) || a_o_ready !== 1'b1 || a_o_count !== 2'd1) begin
        failures++;
        $display("FAIL stream_beat%0d: got v=%0b d=%02h r=%0b cnt=%0d, want v=1 d=%02h r=1 cnt=1",
                 i, a_o_valid, a_o_data, a_o_ready, a_o_count, 8'(i));
      end
    end
    a_valid = 0;
    tick();
    checks++;
    if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: got v=%0b cnt=%0d, want v=0 cnt=0", a_o_valid, a_o_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] nxt, exp;
    bit acc;
    a_rdy_dn = 0; nxt = 8'hA0; a_valid = 1; a_data = nxt;
    for (int k = 0; k < 4; k++) begin
      acc = ra_m;
      tick();
      if (acc) nxt++;
      a_data = nxt;
      if (k == 2) begin
        checks++;
        if (a_o_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_fall: got r=%0b after 3rd accept, want 0", a_o_ready);
        end
      end
    end
    checks++;
    if (a_o_count !== 2'd3 || a_o_ready !== 1'b0 || a_o_data !== 8'hA0 || nxt !== 8'hA3) begin
      failures++;
      $display("FAIL bp_full: got cnt=%0d r=%0b d=%02h next=%02h, want cnt=3 r=0 d=a0 next=a3",
               a_o_count, a_o_ready, a_o_data, nxt);
    end
    a_rdy_dn = 1; exp = 8'hA0;
    for (int k = 0; k < 9; k++) begin
      if (a_o_valid) begin
        checks++;
        if (a_o_data !== exp) begin
          failures++;
          $display("FAIL bp_order: got d=%02h, want %02h", a_o_data, exp);
        end
        exp++;
      end
      acc = a_valid && ra_m;
      tick();
      if (acc) nxt++;
      if (nxt > 8'hA5) a_valid = 0;
      else a_data = nxt;
      if (k == 0) begin
        checks++;
        if (a_o_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_rise: got r=%0b after first pop, want 1", a_o_ready);
        end
      end
      checks++;
      if (a_o_count !== 2'(qa.size()) || a_o_valid !== (qa.size() > 0)) begin
        failures++;
        $display("FAIL bp_model: got cnt=%0d v=%0b, want cnt=%0d", a_o_count, a_o_valid, qa.size());
      end
    end
    checks++;
    if (exp !== 8'hA6) begin
      failures++;
      $display("FAIL bp_delivered: got next_expected=%02h, want a6", exp);
    end
  endtask

  task automatic test_reset_midburst();
    a_rdy_dn = 0; a_valid = 1;
    for (int k = 0; k < 4; k++) begin
      a_data = 8'h30 + 8'(k);
      tick();
    end
    a_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (a_o_valid !== 1'b0 || a_o_ready !== 1'b0 || a_o_count !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%0b r=%0b cnt=%0d, want 0 0 0", a_o_valid, a_o_ready, a_o_count);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ready: got r=%0b v=%0b, want r=1 v=0", a_o_ready, a_o_valid);
    end
    a_valid = 1; a_data = 8'h55; a_rdy_dn = 1;
    tick();
    a_valid = 0;
    checks++;
    if (a_o_valid !== 1'b1 || a_o_data !== 8'h55 || a_o_count !== 2'd1) begin
      failures++;
      $display("FAIL post_reset_beat: got v=%0b d=%02h cnt=%0d, want v=1 d=55 cnt=1",
               a_o_valid, a_o_data, a_o_count);
    end
    tick();
    checks++;
    if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_alone: got v=%0b cnt=%0d, want v=0 cnt=0", a_o_valid, a_o_count);
    end
  endtask

  task automatic test_random_depth3();
    bit acc;
    int seen_full = 0;
    for (int c = 0; c < 10000; c++) begin
      acc = b_valid && rb_m;
      tick();
      checks++;
      if (b_o_valid !== (qb.size() > 0) || b_o_count !== 3'(qb.size()) || b_o_ready !== rb_m ||
          (qb.size() > 0 && b_o_data !== qb[0])) begin
        failures++;
        $display("FAIL rand_cycle%0d: got v=%0b d=%02h cnt=%0d r=%0b, want v=%0b d=%02h cnt=%0d r=%0b",
                 c, b_o_valid, b_o_data, b_o_count, b_o_ready, qb.size() > 0,
                 (qb.size() > 0) ? qb[0] : 8'h00, qb.size(), rb_m);
      end
      if (b_o_count == 3'd4) begin
        seen_full++;
        checks++;
        if (b_o_ready !== 1'b0) begin
          failures++;
          $display("FAIL rand_full_ready: got r=%0b at count 4, want 0", b_o_ready);
        end
      end
      if (acc || !b_valid) begin
        b_valid = 1'($urandom_range(0, 1));
        b_data  = 8'($urandom);
      end
      b_rdy_dn = 1'($urandom_range(0, 1));
    end
    b_valid = 0;
    checks++;
    if (seen_full == 0) begin
      failures++;
      $display("FAIL rand_coverage: got full_cycles=0, want >0");
    end
  endtask

`ifdef CY_SKID_FIFO_FLUSH_EN
  task automatic test_flush();
    a_rdy_dn = 0; a_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_data = 8'h10 + 8'(k);
      tick();
    end
    checks++;
    if (a_o_count !== 2'd3) begin
      failures++;
      $display("FAIL flush_fill: got cnt=%0d, want 3", a_o_count);
    end
    a_flush = 1; a_data = 8'h77;
    tick();
    a_flush = 0; a_valid = 0;
    checks++;
    if (a_o_valid !== 1'b0 || a_o_count !== 2'd0 || a_o_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state: got v=%0b cnt=%0d r=%0b, want v=0 cnt=0 r=1",
               a_o_valid, a_o_count, a_o_ready);
    end
    a_rdy_dn = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (a_o_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_output: got v=%0b d=%02h, want v=0", a_o_valid, a_o_data);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_reset_midburst();
    test_random_depth3();
`ifdef CY_SKID_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
